servo_cmd_ramp: RTL and testbench
=================================

Name: servo_cmd_ramp

Overview:
- Upstream command stage for the servo PWM generator.
- Converts an 8-bit target position and a raw push-button load request into a 17-bit pulse-width command, in clocks of mclk.
- The command ramps toward the target at a fixed step per 20 ms frame.
- Also provides the frame tick and status flags for LEDs.

Parameters:
FRAME_CLKS, 1000000, frame length in mclk cycles (20 ms at 50 MHz)
MIN_W, 50000, pulse width for position 0 (1 ms)
MAX_W, 100000, absolute upper clamp on width
SCALE, 196, width clocks per position LSB (255*196 = 49980)
STEP, 500, maximum width change per frame
DEB_CLKS, 1000000, debounce stable-time in mclk cycles

Ports:
mclk  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
target_pos  in  8  requested position from switches; sampled only on load
load_btn  in  1  raw active-high button; asynchronous, bouncy
hold  in  1  freezes width updates while high
width  out  17  pulse-width command to PWM stage, in mclk cycles
frame_tick  out  1  one-cycle pulse at end of each frame
busy  out  1  high while width != target
at_target  out  1  equals !busy

Behaviour:
- Reset: all state clears immediately when rst_n goes low, not waiting for mclk. Values held during reset:
  - width=MIN_W, target_w=MIN_W, state=IDLE
  - busy=0, at_target=1, frame_tick=0
  - frame counter=0, debouncer output=0
- Input conditioning:
  - load_btn passes through a 2-flop synchronizer, then the debouncer.
  - Debouncer output changes only after the synchronized input holds a new level for DEB_CLKS consecutive cycles; any toggle restarts the count.
  - A rising edge of the debounced level gives a single-cycle load pulse.
  - A held button never reloads.
- Target calculation:
  - On the load pulse: target_w <= min(MIN_W + target_pos*SCALE, MAX_W).
  - Product is 16 bits; sum is 17 bits; no wrap possible at default parameters.
- Frame counter:
  - Counts 0..FRAME_CLKS-1 and wraps to 0.
  - frame_tick=1 exactly in the cycle the count equals FRAME_CLKS-1.
  - Free-running, independent of hold and of state.
- State machine, two states:
  - IDLE -> RAMP on the first cycle where width != target_w.
  - RAMP -> IDLE on the cycle width becomes equal to target_w.
  - busy is registered = (state == RAMP).
- Ramp step (on frame_tick with hold=0, in RAMP):
  - if |target_w - width| <= STEP: width <= target_w (exact landing, no overshoot)
  - else width moves STEP toward target_w
- width changes only on frame_tick cycles; the PWM stage therefore sees a stable value for the whole frame.
- Boundary cases:
  - Load and frame_tick in the same cycle: the step uses the old target_w; the new target takes effect from the next frame.
  - Load during RAMP: retargets. Direction may reverse on the next frame; no extra delay.
  - Load equal to current width: state stays IDLE.
  - hold=1: width frozen and frame counter keeps running. Loads are still accepted, and busy reflects the mismatch.
  - target_pos changes without a load pulse are ignored.
  - Reset mid-ramp: width returns to MIN_W immediately; the ramp does not resume after reset release.
- Latency:
  - Button press to load pulse = 2 sync cycles + DEB_CLKS + 1 edge cycle.
  - Load pulse to first width change = next frame_tick.

Decomposition:
- Shared package servo_pkg holds:
  - W_BITS=17 and FRAME_CLKS
  - MIN_W/MAX_W/STEP defaults
  - the state encoding (IDLE=0, RAMP=1)
- The PWM generator imports the same package so width semantics match.
- One sub-module, btn_debounce:
  - contains the synchronizer, the stable-count counter and the rising-edge pulse
  - parameter DEB_CLKS
  - ports mclk, rst_n, raw, level, rise

Test Plan:
- Bench parameters: FRAME_CLKS=100, DEB_CLKS=4, other parameters at default.
- Reset: assert rst_n=0 with width=75000 mid-ramp -> width=50000, busy=0, at_target=1, frame_tick=0 in the same cycle (asynchronous). After release, frame_tick first pulses at cycle 99.
- Full ramp: target_pos=255, press held 10 cycles -> load pulse 7 cycles after the press; target_w=99980. width reads 50500, 51000 … 99500 over 99 frames; the 100th tick gives 99980 and busy falls in that cycle.
- Bounce rejection: load_btn high for 3 cycles, low for 2, high for 3, then low -> no load; width and busy unchanged. Holding the button for 50 cycles gives exactly one load.
- Retarget and reverse: after the ramp to 99980, at width=60000 load target_pos=0 -> the next frames give 59500, 59000 … 50000, then busy=0.
- Simultaneous and hold:
  - Load target_pos=1 (target 50196) in the frame_tick cycle while width=50000 -> width stays 50000 at that tick; the next tick gives 50196.
  - Assert hold for 10 frames during a ramp -> width constant and frame_tick still pulsing; it resumes stepping on the first tick after hold falls.

Source files
------------

// File: rtl/servo_pkg.sv
// Purpose : shared widths, default timing constants and state encoding for the servo command path.
// Latency : n/a (package only).
// Backpres: n/a; the PWM stage imports this so width semantics match on both sides.
package servo_pkg;

    localparam int W_BITS = 17;

    // Defaults for a 50 MHz mclk: 20 ms frame, 1 ms..2 ms pulse range.
    localparam int unsigned DEF_FRAME_CLKS = 1000000;
    localparam int unsigned DEF_MIN_W      = 50000;
    localparam int unsigned DEF_MAX_W      = 100000;
    localparam int unsigned DEF_SCALE      = 196;
    localparam int unsigned DEF_STEP       = 500;
    localparam int unsigned DEF_DEB_CLKS   = 1000000;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RAMP = 1'b1;

    // Position -> pulse width, clamped to the absolute upper limit.
    function automatic logic [W_BITS-1:0] calc_target(
        input logic [7:0]  pos,
        input int unsigned min_w,
        input int unsigned scale,
        input int unsigned max_w
    );
        int unsigned sum;
        sum = min_w + 32'(pos) * scale;
        if (sum > max_w) begin
            sum = max_w;
        end
        return W_BITS'(sum);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Purpose : synchronise and debounce a raw push-button, emit a one-cycle pulse on a debounced rising edge.
// Latency : raw -> level = 2 sync + DEB_CLKS cycles; level -> rise = 1 cycle.
// Backpres: none; free-running conditioning of an asynchronous level input.
//
// Ports: mclk/rst_n clock and async active-low reset; raw bouncy button;
//        level debounced state; rise single-cycle pulse when level goes 0->1.
module btn_debounce #(
    parameter int unsigned DEB_CLKS = 1000000
) (
    input  logic mclk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = (DEB_CLKS > 1) ? $clog2(DEB_CLKS) : 1;

    logic          sync_q1;
    logic          sync_q2;
    logic          level_d;
    logic [CW-1:0] stable_cnt;

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1    <= 1'b0;
            sync_q2    <= 1'b0;
            level      <= 1'b0;
            level_d    <= 1'b0;
            rise       <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
            level_d <= level;
            rise    <= level & ~level_d;
            // Count consecutive cycles at the opposite level; any return to
            // the current level throws the partial count away.
            if (sync_q2 == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CW'(DEB_CLKS - 1)) begin
                level      <= sync_q2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/servo_cmd_ramp.sv
// Purpose : turn a debounced load request + 8-bit position into a slew-limited PWM width command.
// Latency : load pulse -> target next cycle; width moves only on frame_tick (at most STEP per frame).
// Backpres: none; hold freezes width updates while the frame counter keeps running.
//
// Ports: mclk/rst_n clock and async active-low reset; target_pos switch position
//        (sampled on load only); load_btn raw button; hold freeze; width command;
//        frame_tick end-of-frame pulse; busy/at_target ramp status for LEDs.
module servo_cmd_ramp
    import servo_pkg::*;
#(
    parameter int unsigned FRAME_CLKS = DEF_FRAME_CLKS,
    parameter int unsigned MIN_W      = DEF_MIN_W,
    parameter int unsigned MAX_W      = DEF_MAX_W,
    parameter int unsigned SCALE      = DEF_SCALE,
    parameter int unsigned STEP       = DEF_STEP,
    parameter int unsigned DEB_CLKS   = DEF_DEB_CLKS
) (
    input  logic              mclk,
    input  logic              rst_n,
    input  logic [7:0]        target_pos,
    input  logic              load_btn,
    input  logic              hold,
    output logic [W_BITS-1:0] width,
    output logic              frame_tick,
    output logic              busy,
    output logic              at_target
);

    localparam int FC_W = (FRAME_CLKS > 1) ? $clog2(FRAME_CLKS) : 1;

    logic [FC_W-1:0]   frame_cnt;
    logic              deb_level;
    logic              deb_rise;
    logic              load_evt;
    logic [W_BITS-1:0] target_w;
    logic [W_BITS-1:0] width_nxt;
    logic [W_BITS-1:0] target_nxt;
    logic [0:0]        state;
    logic [0:0]        state_nxt;

    btn_debounce #(
        .DEB_CLKS (DEB_CLKS)
    ) u_btn_debounce (
        .mclk  (mclk),
        .rst_n (rst_n),
        .raw   (load_btn),
        .level (deb_level),
        .rise  (deb_rise)
    );

    // A load only counts while the debounced level is still asserted.
    assign load_evt   = deb_rise & deb_level;
    assign frame_tick = (frame_cnt == FC_W'(FRAME_CLKS - 1));

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (frame_tick) begin
            frame_cnt <= '0;
        end else begin
            frame_cnt <= frame_cnt + FC_W'(1);
        end
    end

    always_comb begin
        width_nxt = width;
        // Step against the current target_w, so a load landing on the tick
        // cycle only takes effect from the following frame.
        if (frame_tick && !hold && (state == ST_RAMP)) begin
            if (target_w > width) begin
                if ((target_w - width) <= W_BITS'(STEP)) begin
                    width_nxt = target_w;
                end else begin
                    width_nxt = width + W_BITS'(STEP);
                end
            end else begin
                if ((width - target_w) <= W_BITS'(STEP)) begin
                    width_nxt = target_w;
                end else begin
                    width_nxt = width - W_BITS'(STEP);
                end
            end
        end

        target_nxt = load_evt ? calc_target(target_pos, MIN_W, SCALE, MAX_W) : target_w;

        // Enter RAMP the first cycle a mismatch exists, leave it on the edge
        // that lands width on the target.
        state_nxt = (width_nxt != target_nxt) ? ST_RAMP : ST_IDLE;
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            width    <= W_BITS'(MIN_W);
            target_w <= W_BITS'(MIN_W);
            state    <= ST_IDLE;
        end else begin
            width    <= width_nxt;
            target_w <= target_nxt;
            state    <= state_nxt;
        end
    end

    assign busy      = (state == ST_RAMP);
    assign at_target = ~busy;

endmodule

// File: tb/tb_servo_cmd_ramp.sv
module tb_servo_cmd_ramp;

    localparam int FRAME = 100;
    localparam int DEB   = 4;
    localparam int MIN_W = 50000;
    localparam int MAX_W = 100000;
    localparam int SCALE = 196;
    localparam int STEP  = 500;

    logic        mclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  target_pos = 8'd0;
    logic        load_btn = 1'b0;
    logic        hold = 1'b0;
    logic [16:0] width;
    logic        frame_tick;
    logic        busy;
    logic        at_target;

    int n_chk  = 0;
    int n_fail = 0;

    servo_cmd_ramp #(
        .FRAME_CLKS (FRAME),
        .DEB_CLKS   (DEB)
    ) dut (
        .mclk       (mclk),
        .rst_n      (rst_n),
        .target_pos (target_pos),
        .load_btn   (load_btn),
        .hold       (hold),
        .width      (width),
        .frame_tick (frame_tick),
        .busy       (busy),
        .at_target  (at_target)
    );

    always #5 mclk = ~mclk;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int tgt(input int pos);
        int s;
        s = MIN_W + pos * SCALE;
        return (s > MAX_W) ? MAX_W : s;
    endfunction

    // ---------------- behavioural model ----------------
    // Debounce: the level flips once the DEB most recent synchronised samples
    // (raw delayed by two cycles) all differ from it; the resulting load is
    // applied two edges after the flip.
    int m_w, m_t, m_fc;
    bit m_lvl, m_lv1, m_lv2, m_lv3;
    bit hist[$];

    always @(negedge mclk) begin : model
        bit ld;
        bit flip;
        int diff;
        if (!rst_n) begin
            m_w = MIN_W; m_t = MIN_W; m_fc = 0;
            m_lvl = 0; m_lv1 = 0; m_lv2 = 0; m_lv3 = 0;
            hist.delete();
            for (int i = 0; i < DEB + 2; i++) hist.push_back(1'b0);
        end
        check("model_width", int'(width), m_w);
        check("model_tick", int'(frame_tick), (m_fc == FRAME - 1) ? 1 : 0);
        check("model_busy", int'(busy), (m_w != m_t) ? 1 : 0);
        check("model_at_target", int'(at_target), (m_w == m_t) ? 1 : 0);
        if (rst_n) begin
            hist.push_back(load_btn);
            void'(hist.pop_front());
            flip = 1;
            for (int i = 0; i < DEB; i++) if (hist[i] == m_lvl) flip = 0;
            ld = m_lv2 && !m_lv3;
            if (flip) m_lvl = !m_lvl;
            m_lv3 = m_lv2; m_lv2 = m_lv1; m_lv1 = m_lvl;
            if (m_fc == FRAME - 1 && !hold && m_w != m_t) begin
                diff = (m_t > m_w) ? (m_t - m_w) : (m_w - m_t);
                if (diff <= STEP) m_w = m_t;
                else if (m_t > m_w) m_w = m_w + STEP;
                else m_w = m_w - STEP;
            end
            if (ld) m_t = tgt(int'(target_pos));
            m_fc = (m_fc + 1) % FRAME;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    // Returns just after the edge that ends the next frame_tick cycle.
    task automatic frame_update();
        int k;
        k = 0;
        while (frame_tick !== 1'b1 && k < FRAME + 5) begin
            step();
            k++;
        end
        if (frame_tick !== 1'b1) begin
            n_chk++;
            n_fail++;
            $display("FAIL frame_tick_timeout: got no tick in %0d cycles, expected one", k);
        end
        step();
    endtask

    task automatic press(input int pos, input int cycles);
        target_pos = 8'(pos);
        load_btn = 1'b1;
        repeat (cycles) step();
        load_btn = 1'b0;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no finish by %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

    initial begin : main
        int k;
        // Reset state and first frame tick
        repeat (3) step();
        check("rst_width", int'(width), 50000);
        check("rst_busy", int'(busy), 0);
        check("rst_at_target", int'(at_target), 1);
        check("rst_tick", int'(frame_tick), 0);
        rst_n = 1'b1;
        k = 0;
        while (frame_tick !== 1'b1 && k < 200) begin
            step();
            k++;
        end
        check("first_tick_cycle", k, 99);

        // Load landing on the tick edge: old target used, new one next frame
        repeat (93) step();
        press(1, 10);
        check("simul_width_old", int'(width), 50000);
        check("simul_busy", int'(busy), 1);
        frame_update();
        check("simul_width_new", int'(width), 50196);
        check("simul_idle", int'(busy), 0);

        // Bounce rejection
        target_pos = 8'd255;
        load_btn = 1'b1; repeat (3) step();
        load_btn = 1'b0; repeat (2) step();
        load_btn = 1'b1; repeat (3) step();
        load_btn = 1'b0;
        repeat (3) frame_update();
        check("bounce_width", int'(width), 50196);
        check("bounce_busy", int'(busy), 0);

        // Long hold loads once; later target_pos change is ignored
        target_pos = 8'd0;
        load_btn = 1'b1;
        repeat (20) step();
        target_pos = 8'd200;
        repeat (30) step();
        load_btn = 1'b0;
        repeat (3) frame_update();
        check("held_once_width", int'(width), 50000);
        check("held_once_busy", int'(busy), 0);

        // Reset mid-ramp
        press(255, 10);
        repeat (50) frame_update();
        check("mid_ramp_width", int'(width), 75000);
        repeat (20) step();
        rst_n = 1'b0;
        #1;
        check("async_rst_width", int'(width), 50000);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_at_target", int'(at_target), 1);
        check("async_rst_tick", int'(frame_tick), 0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (3) frame_update();
        check("no_resume_width", int'(width), 50000);
        check("no_resume_busy", int'(busy), 0);

        // Full ramp with load latency
        target_pos = 8'd255;
        load_btn = 1'b1;
        repeat (7) step();
        check("load_lat_before", int'(busy), 0);
        step();
        check("load_lat_after", int'(busy), 1);
        repeat (2) step();
        load_btn = 1'b0;
        for (int f = 1; f <= 100; f++) begin
            frame_update();
            check("ramp_width", int'(width), (f < 100) ? (50000 + 500 * f) : 99980);
            check("ramp_busy", int'(busy), (f < 100) ? 1 : 0);
        end

        // Retarget and reverse, with hold during the descent
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        press(255, 10);
        repeat (20) frame_update();
        check("retgt_start", int'(width), 60000);
        press(0, 10);
        frame_update();
        check("reverse_first", int'(width), 59500);
        hold = 1'b1;
        for (int f = 0; f < 10; f++) begin
            frame_update();
            check("hold_width", int'(width), 59500);
            check("hold_busy", int'(busy), 1);
        end
        hold = 1'b0;
        frame_update();
        check("hold_resume", int'(width), 59000);
        repeat (18) frame_update();
        check("reverse_end_width", int'(width), 50000);
        check("reverse_end_busy", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
